// File: rtl/bls12_381_fe2_mul_arb_pkg.sv
// rtl/bls12_381_fe2_mul_arb_pkg.sv - shared types and round-robin helper for the FE2 multiplier arbiter
package bls12_381_fe2_mul_arb_pkg;

  localparam int FE2_ARB_BIT = 20;
  localparam int MAX_REQ     = 8;

  typedef enum logic {
    FE2_ARB_IDLE   = 1'b0,
    FE2_ARB_LOCKED = 1'b1
  } fe2_mul_arb_state_t;

  // First set bit of val_vec searching last+1, last+2, ... modulo num.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] val_vec, input int last, input int num);
    int   pick;
    int   idx;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (last + i) % num;
      if (!found && i <= num && val_vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bls12_381_fe2_mul_arb_if.sv
// rtl/bls12_381_fe2_mul_arb_if.sv - packet stream bundle with sop/eop framing and ctl sideband
interface bls12_381_fe2_mul_arb_if #(
  parameter int DAT_BITS = 762,
  parameter int CTL_BITS = 32
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, sop, eop, err, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, output rdy);
endinterface

// File: rtl/bls12_381_fe2_mul_arb.sv
// rtl/bls12_381_fe2_mul_arb.sv - packet round-robin arbiter sharing one FE2 multiplier, tag-routed return
module bls12_381_fe2_mul_arb
  import bls12_381_fe2_mul_arb_pkg::*;
#(
  parameter int DAT_BITS = 762,
  parameter int CTL_BITS = 32,
  parameter int NUM_REQ  = 3,
  parameter int ARB_BIT  = FE2_ARB_BIT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  bls12_381_fe2_mul_arb_if.slave  i_req_if [NUM_REQ],
  bls12_381_fe2_mul_arb_if.master o_rsp_if [NUM_REQ],
  bls12_381_fe2_mul_arb_if.master o_mul_fe2_if,
  bls12_381_fe2_mul_arb_if.slave  i_mul_fe2_if,
  output logic                    o_err
);
  localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fe2_mul_arb_state_t  state_q, state_d;
  logic [TW-1:0]       gnt_q, gnt_d, last_q, last_d, sel, pick, rtn_tag;
  logic                accept, out_free, rtn_hit, err_q;
  logic [NUM_REQ-1:0]  req_val, req_sop, req_eop, req_err, req_rdy, req_rdy_raw;
  logic [NUM_REQ-1:0]  rsp_rdy, rsp_sel, tag_hot;
  logic [DAT_BITS-1:0] req_dat [NUM_REQ];
  logic [CTL_BITS-1:0] req_ctl [NUM_REQ];

  logic                out_val_q, out_sop_q, out_eop_q, out_err_q;
  logic [DAT_BITS-1:0] out_dat_q;
  logic [CTL_BITS-1:0] out_ctl_q, out_ctl_d;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    assign req_val[k]       = i_req_if[k].val;
    assign req_sop[k]       = i_req_if[k].sop;
    assign req_eop[k]       = i_req_if[k].eop;
    assign req_err[k]       = i_req_if[k].err;
    assign req_dat[k]       = i_req_if[k].dat;
    assign req_ctl[k]       = i_req_if[k].ctl;
    assign i_req_if[k].rdy  = req_rdy[k];
    assign o_rsp_if[k].val  = rsp_sel[k];
    assign o_rsp_if[k].sop  = i_mul_fe2_if.sop;
    assign o_rsp_if[k].eop  = i_mul_fe2_if.eop;
    assign o_rsp_if[k].err  = i_mul_fe2_if.err;
    assign o_rsp_if[k].dat  = i_mul_fe2_if.dat;
    assign o_rsp_if[k].ctl  = i_mul_fe2_if.ctl;
    assign rsp_rdy[k]       = o_rsp_if[k].rdy;
  end

  assign out_free = ~out_val_q | o_mul_fe2_if.rdy;
  assign pick     = TW'(rr_pick(MAX_REQ'(req_val), int'(last_q), NUM_REQ));
  // Grants must read low while reset is held, even though the output register looks free.
  assign req_rdy  = req_rdy_raw & {NUM_REQ{i_rst_n}};

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    sel         = gnt_q;
    accept      = 1'b0;
    req_rdy_raw = '0;
    unique case (state_q)
      FE2_ARB_IDLE: begin
        if (|req_val && out_free) begin
          sel               = pick;
          gnt_d             = pick;
          last_d            = pick;
          accept            = 1'b1;
          req_rdy_raw[pick] = 1'b1;
          state_d           = req_eop[pick] ? FE2_ARB_IDLE : FE2_ARB_LOCKED;
        end
      end
      FE2_ARB_LOCKED: begin
        req_rdy_raw[gnt_q] = out_free;
        accept             = req_val[gnt_q] & out_free;
        if (accept && req_eop[gnt_q]) state_d = FE2_ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    out_ctl_d                = req_ctl[sel];
    out_ctl_d[ARB_BIT +: TW] = sel;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FE2_ARB_IDLE;
      gnt_q     <= '0;
      last_q    <= TW'(NUM_REQ - 1);
      out_val_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_err_q <= 1'b0;
      out_dat_q <= '0;
      out_ctl_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      if (accept) begin
        out_val_q <= 1'b1;
        out_sop_q <= req_sop[sel];
        out_eop_q <= req_eop[sel];
        out_err_q <= req_err[sel];
        out_dat_q <= req_dat[sel];
        out_ctl_q <= out_ctl_d;
      end else if (o_mul_fe2_if.rdy) begin
        out_val_q <= 1'b0;
      end
      if (i_mul_fe2_if.val && !rtn_hit) err_q <= 1'b1;
    end
  end

  assign o_mul_fe2_if.val = out_val_q;
  assign o_mul_fe2_if.sop = out_sop_q;
  assign o_mul_fe2_if.eop = out_eop_q;
  assign o_mul_fe2_if.err = out_err_q;
  assign o_mul_fe2_if.dat = out_dat_q;
  assign o_mul_fe2_if.ctl = out_ctl_q;
  assign o_err            = err_q;

  // Return demux: a tag outside 0..NUM_REQ-1 matches nobody and is swallowed.
  assign rtn_tag = i_mul_fe2_if.ctl[ARB_BIT +: TW];

  always_comb begin
    tag_hot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      tag_hot[k] = (rtn_tag == TW'(k));
    end
    rtn_hit = |tag_hot;
    rsp_sel = tag_hot & {NUM_REQ{i_mul_fe2_if.val}};
  end

  assign i_mul_fe2_if.rdy = ~rtn_hit | (|(rsp_rdy & tag_hot));

endmodule
